// File: rtl/booth_mult_unit.sv
// Iterative radix-2 Booth signed multiplier built on a ripple of eight_bit_cla slices.
// Optional MULT_ZERO_BYPASS_EN: a zero operand skips the iteration and finishes in one cycle.
module eight_bit_cla (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] s,
  output logic       g_out,
  output logic       p_out
);
  logic [7:0] gen;
  logic [7:0] prop;
  logic [8:0] carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    carry[0] = c_in;
    g_out    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
      g_out      = gen[i] | (prop[i] & g_out);
    end
  end

  assign s     = prop ^ carry[7:0];
  assign p_out = &prop;
endmodule

module booth_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int AW = WIDTH + 8;
  localparam int NS = AW / 8;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH % 8 != 0) begin : g_width_check
      $error("booth_mult_unit: WIDTH must be a multiple of 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    m_reg;
  logic [AW-1:0]    acc_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_1_reg;
  logic [CW-1:0]    count_reg;

  logic             add_en;
  logic             sub;
  logic [AW-1:0]    add_b;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    step_acc;
  logic [NS:0]      slice_c;
  logic [NS-1:0]    slice_g;
  logic [NS-1:0]    slice_p;
  logic             start;
  logic             zero_op;
  logic             exc_calc;
  logic [WIDTH:0]   upper_bits;

  assign add_en = q_reg[0] ^ q_1_reg;
  assign sub    = q_reg[0] & ~q_1_reg;
  assign add_b  = sub ? ~m_reg : m_reg;

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_slice
      eight_bit_cla u_cla (
        .a     (acc_reg[gi*8 +: 8]),
        .b     (add_b[gi*8 +: 8]),
        .c_in  (slice_c[gi]),
        .s     (sum[gi*8 +: 8]),
        .g_out (slice_g[gi]),
        .p_out (slice_p[gi])
      );
    end
  endgenerate

  // Slice group G/P do not depend on the slice carry-in, so this chain has no loop.
  always_comb begin
    slice_c[0] = sub;
    for (int k = 0; k < NS; k++) begin
      slice_c[k+1] = slice_g[k] | (slice_p[k] & slice_c[k]);
    end
  end

  assign step_acc   = add_en ? sum : acc_reg;
  assign upper_bits = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign exc_calc   = ~((&upper_bits) | ~(|upper_bits));
  assign start      = ctrl_MULT && (state != RUN);

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (data_operandA == '0) || (data_operandB == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      m_reg          <= '0;
      acc_reg        <= '0;
      q_reg          <= '0;
      q_1_reg        <= 1'b0;
      count_reg      <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        RUN: begin
          acc_reg   <= {step_acc[AW-1], step_acc[AW-1:1]};
          q_reg     <= {step_acc[0], q_reg[WIDTH-1:1]};
          q_1_reg   <= q_reg[0];
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          data_result    <= q_reg;
          data_exception <= exc_calc;
          data_resultRDY <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A start taken in DONE still publishes the finished result on the same edge.
      if (start) begin
        m_reg     <= {{8{data_operandA[WIDTH-1]}}, data_operandA};
        acc_reg   <= '0;
        q_reg     <= zero_op ? '0 : data_operandB;
        q_1_reg   <= 1'b0;
        count_reg <= '0;
        state     <= zero_op ? DONE : RUN;
        busy      <= ~zero_op;
        if (state == IDLE) data_exception <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed-vector bench for booth_mult_unit: latency, busy width, results, exceptions,
// restart-ignore, mid-run reset, back-to-back starts and the zero-operand path.
module tb_booth_mult_unit;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int total_cnt = 0;
  int pass_cnt  = 0;

  booth_mult_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else begin
      pass_cnt++;
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One start pulse, then wait (bounded) for RDY and check latency, busy width and outputs.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_e,
                        input int exp_lat, input int exp_busy);
    int n;
    int bcnt;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h1234_5678;
    bcnt = busy ? 1 : 0;
    n = 0;
    while (!data_resultRDY && n < 100) begin
      @(posedge clock);
      #1;
      n++;
      if (busy) bcnt++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " busy"}, 64'(bcnt), 64'(exp_busy));
    check({tag, " result"}, 64'(data_result), 64'(exp_r));
    check({tag, " exc"}, 64'(data_exception), 64'(exp_e));
    @(posedge clock);
    #1;
    check({tag, " rdy_drop"}, 64'(data_resultRDY), 64'd0);
    check({tag, " hold"}, 64'(data_result), 64'(exp_r));
  endtask

  initial begin
    int n;
    int lat;
    int rdy_cnt;
    reset_n = 1'b0;
    ctrl_MULT = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset result", 64'(data_result), 64'd0);
    check("reset rdy", 64'(data_resultRDY), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset exc", 64'(data_exception), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("6x7", 32'd6, 32'd7, 32'd42, 1'b0, 33, 32);
    run_op("-3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 33, 32);
    run_op("-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 32);
    run_op("min x -1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33, 32);
    run_op("2^16 x 2^16", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 33, 32);
    run_op("min x min", 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 33, 32);
    run_op("max x 2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, 33, 32);
    run_op("max x -1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 33, 32);

    // A second start while running must be ignored.
    @(negedge clock);
    data_operandA = 32'd6;
    data_operandB = 32'd7;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    lat = 0;
    for (n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clock);
      #1;
      if (n == 9) begin
        data_operandA = 32'd2;
        data_operandB = 32'd2;
        ctrl_MULT = 1'b1;
      end
      if (n == 10) ctrl_MULT = 1'b0;
      if (data_resultRDY) lat = n;
    end
    check("restart ignored latency", 64'(lat), 64'd33);
    check("restart ignored result", 64'(data_result), 64'd42);

    // Reset mid-run abandons the operation.
    @(negedge clock);
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset result", 64'(data_result), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset rdy", 64'(data_resultRDY), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rdy_cnt = 0;
    for (n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_cnt++;
    end
    check("midreset no rdy", 64'(rdy_cnt), 64'd0);
    run_op("after reset", 32'd11, 32'hFFFF_FFFE, 32'hFFFF_FFEA, 1'b0, 33, 32);

    // Back-to-back: ctrl_MULT held so the second op starts from DONE.
    @(negedge clock);
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    data_operandA = 32'hFFFF_FFFB;
    data_operandB = 32'd9;
    lat = 0;
    for (n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) lat = n;
    end
    ctrl_MULT = 1'b0;
    check("b2b first latency", 64'(lat), 64'd33);
    check("b2b first result", 64'(data_result), 64'd12);
    lat = 0;
    for (n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) lat = n;
    end
    check("b2b second latency", 64'(lat), 64'd33);
    check("b2b second result", 64'(data_result), 64'hFFFF_FFD3);
    check("b2b second exc", 64'(data_exception), 64'd0);

`ifdef MULT_ZERO_BYPASS_EN
    run_op("0x123", 32'd0, 32'd123, 32'd0, 1'b0, 1, 0);
`else
    run_op("0x123", 32'd0, 32'd123, 32'd0, 1'b0, 33, 32);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
